// File: rtl/ipg_rresp_gen_if.sv
// Job request and IPG chunk bus between the memory read path, the response
// generator and the PHY gap-insertion logic.
interface ipg_rresp_gen_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int HDR_WIDTH   = 16,
    parameter int ADR_WIDTH   = 40,
    parameter int PAYLOAD_LEN = 512
) ();
    logic                   req_valid;
    logic                   req_ready;
    logic [ADR_WIDTH-1:0]   req_addr;
    logic [HDR_WIDTH-1:0]   req_len;
    logic [PAYLOAD_LEN-1:0] req_payload;
    logic [6:0]             tx_len;
    logic [DATA_WIDTH-1:0]  tx_ipg_data;
    logic [6:0]             tx_used;
    logic                   rresp_valid;
    logic                   done;

    modport master (
        output req_valid, req_addr, req_len, req_payload, tx_len,
        input  req_ready, tx_ipg_data, tx_used, rresp_valid, done
    );

    modport slave (
        input  req_valid, req_addr, req_len, req_payload, tx_len,
        output req_ready, tx_ipg_data, tx_used, rresp_valid, done
    );
endinterface

// File: rtl/ipg_rresp_gen.sv
// Serializes one read-response job (header + payload) into MSB-aligned IPG
// chunks, consuming only as many bits per cycle as the gap budget allows.
module ipg_rresp_gen #(
    parameter int DATA_WIDTH  = 64,
    parameter int HDR_WIDTH   = 16,
    parameter int ADR_WIDTH   = 40,
    parameter int PAYLOAD_LEN = 512
) (
    input logic             clk,
    input logic             reset,
    ipg_rresp_gen_if.slave  bus
);
    localparam int REM_W = $clog2(PAYLOAD_LEN + 1);
    localparam int LEN_W = 7;
    localparam int PAD_W = DATA_WIDTH - HDR_WIDTH - ADR_WIDTH;

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t                 state;
    logic [REM_W-1:0]       rem;
    logic [ADR_WIDTH-1:0]   addr_q;
    logic [PAYLOAD_LEN-1:0] payload_q;

    logic [LEN_W-1:0]       tx_cap;
    logic [LEN_W-1:0]       n;
    logic [REM_W-1:0]       shamt;
    logic [REM_W-1:0]       len_clamp;
    logic [DATA_WIDTH-1:0]  chunk;
    logic [DATA_WIDTH-1:0]  hdr;

    assign bus.req_ready = (state == IDLE);

    always_comb begin
        tx_cap    = (bus.tx_len > LEN_W'(DATA_WIDTH)) ? LEN_W'(DATA_WIDTH) : bus.tx_len;
        n         = (REM_W'(tx_cap) < rem) ? tx_cap : LEN_W'(rem);
        len_clamp = (bus.req_len > HDR_WIDTH'(PAYLOAD_LEN)) ? REM_W'(PAYLOAD_LEN)
                                                          : REM_W'(bus.req_len);
        // Left-justify the next unsent bit, take the top word, keep only n bits.
        shamt     = REM_W'(PAYLOAD_LEN) - rem;
        chunk     = DATA_WIDTH'((payload_q << shamt) >> (PAYLOAD_LEN - DATA_WIDTH))
                  & ~({DATA_WIDTH{1'b1}} >> n);
        hdr       = {HDR_WIDTH'(rem), addr_q, {PAD_W{1'b0}}};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            rem             <= '0;
            addr_q          <= '0;
            payload_q       <= '0;
            bus.tx_ipg_data <= '0;
            bus.tx_used     <= '0;
            bus.rresp_valid <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            bus.tx_ipg_data <= '0;
            bus.tx_used     <= '0;
            bus.rresp_valid <= 1'b0;
            bus.done        <= 1'b0;
            case (state)
                IDLE: if (bus.req_valid) begin
                    addr_q    <= bus.req_addr;
                    payload_q <= bus.req_payload;
                    rem       <= len_clamp;
                    state     <= HDR;
                end
                HDR: if (tx_cap >= LEN_W'(HDR_WIDTH + ADR_WIDTH)) begin
                    // Header goes out whole; rem already holds the clamped length.
                    bus.rresp_valid <= 1'b1;
                    bus.tx_ipg_data <= hdr;
                    bus.tx_used     <= LEN_W'(HDR_WIDTH + ADR_WIDTH);
                    if (rem == '0) begin
                        bus.done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        state    <= DATA;
                    end
                end
                DATA: if (tx_cap != '0) begin
                    bus.rresp_valid <= 1'b1;
                    bus.tx_ipg_data <= chunk;
                    bus.tx_used     <= n;
                    rem             <= rem - REM_W'(n);
                    if (rem == REM_W'(n)) begin
                        bus.done <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ipg_rresp_gen.sv
// Directed bench: expected chunks are queued by the stimulus and popped by a
// negedge monitor whenever the generator presents a chunk.
module tb_ipg_rresp_gen;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ipg_rresp_gen_if bus ();
    ipg_rresp_gen dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [63:0] data;
        logic [6:0]  used;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic push(input logic [63:0] d, input logic [6:0] u, input logic dn);
        exp_t e;
        e.data = d; e.used = u; e.done = dn;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (reset && bus.rresp_valid) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_chunk: got data %h used %0d", bus.tx_ipg_data, bus.tx_used);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("chunk_data", bus.tx_ipg_data, e.data);
                chk("chunk_used", 64'(bus.tx_used), 64'(e.used));
                chk("chunk_done", 64'(bus.done), 64'(e.done));
            end
        end
    end

    task automatic send_job(input logic [39:0] a, input logic [15:0] l, input logic [511:0] p);
        int t;
        t = 0;
        while (!bus.req_ready && t < 50) begin tick(); t++; end
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1; bus.req_addr = a; bus.req_len = l; bus.req_payload = p;
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr = '1; bus.req_len = '1; bus.req_payload = '1;
        chk("req_ready_busy", 64'(bus.req_ready), 64'd0);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin tick(); t++; end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout: %0d chunks outstanding, expected 0", sb.size());
            sb.delete();
        end
        tick(); tick();
    endtask

    logic [511:0] pl;
    logic [63:0]  w [8];

    initial begin
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_len = '0;
        bus.req_payload = '0; bus.tx_len = 7'd64;
        #3;
        chk("rst_valid", 64'(bus.rresp_valid), 64'd0);
        chk("rst_data", bus.tx_ipg_data, 64'd0);
        chk("rst_used", 64'(bus.tx_used), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk); reset = 1'b1;
        tick();

        // Header plus two full chunks
        bus.tx_len = 7'd64;
        push(64'h0080_1234_5678_9A00, 7'd56, 1'b0);
        push(64'h0123_4567_89AB_CDEF, 7'd64, 1'b0);
        push(64'hFEDC_BA98_7654_3210, 7'd64, 1'b1);
        pl = '0; pl[127:0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        send_job(40'h12_3456_789A, 16'd128, pl);
        wait_drain();

        // Header stall while the gap is too small
        bus.tx_len = 7'd40;
        push(64'h0040_00AB_CDEF_0100, 7'd56, 1'b0);
        push(64'hDEAD_BEEF_CAFE_F00D, 7'd64, 1'b1);
        pl = '0; pl[63:0] = 64'hDEAD_BEEF_CAFE_F00D;
        send_job(40'h00_ABCD_EF01, 16'd64, pl);
        repeat (5) begin tick(); chk("stall_no_valid", 64'(bus.rresp_valid), 64'd0); end
        bus.tx_len = 7'd64;
        tick();
        chk("stall_hdr_valid", 64'(bus.rresp_valid), 64'd1);
        wait_drain();

        // Odd 30-bit split with a 3-cycle gap mid-payload
        bus.tx_len = 7'd64;
        push(64'h0064_5555_6666_7700, 7'd56, 1'b0);
        push({30'h1234_5678, 34'h0}, 7'd30, 1'b0);
        push({30'h0ABC_DEF0, 34'h0}, 7'd30, 1'b0);
        push({30'h3000_0001, 34'h0}, 7'd30, 1'b0);
        push({10'h2A5, 54'h0}, 7'd10, 1'b1);
        pl = '0; pl[99:0] = {30'h1234_5678, 30'h0ABC_DEF0, 30'h3000_0001, 10'h2A5};
        send_job(40'h55_5566_6677, 16'd100, pl);
        tick();
        bus.tx_len = 7'd30;
        tick(); tick();
        bus.tx_len = 7'd0;
        repeat (3) begin tick(); chk("gap_no_valid", 64'(bus.rresp_valid), 64'd0); end
        bus.tx_len = 7'd30;
        wait_drain();

        // Length clamp to 512 and gap clamp to 64
        bus.tx_len = 7'd100;
        push(64'h0200_0102_0304_0500, 7'd56, 1'b0);
        for (int k = 0; k < 8; k++) begin
            w[k] = 64'h0F1E_2D3C_4B5A_0000 | 64'(k);
            pl[511 - 64*k -: 64] = w[k];
            push(w[k], 7'd64, k == 7);
        end
        send_job(40'h01_0203_0405, 16'd600, pl);
        wait_drain();

        // Asynchronous reset mid-DATA, then a fresh job
        bus.tx_len = 7'd64;
        push(64'h0080_0A0B_0C0D_0E00, 7'd56, 1'b0);
        push(64'h1111_2222_3333_4444, 7'd64, 1'b0);
        pl = '0; pl[127:0] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        send_job(40'h0A_0B0C_0D0E, 16'd128, pl);
        tick(); tick();
        @(negedge clk); #1;
        chk("pre_rst_valid", 64'(bus.rresp_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.rresp_valid), 64'd0);
        chk("mid_rst_data", bus.tx_ipg_data, 64'd0);
        chk("mid_rst_used", 64'(bus.tx_used), 64'd0);
        chk("mid_rst_ready", 64'(bus.req_ready), 64'd1);
        repeat (3) tick();
        chk("mid_rst_sb_empty", 64'(sb.size()), 64'd0);
        @(negedge clk); reset = 1'b1;
        push(64'h0040_7766_5544_3300, 7'd56, 1'b0);
        push(64'h1357_9BDF_2468_ACE0, 7'd64, 1'b1);
        pl = '0; pl[63:0] = 64'h1357_9BDF_2468_ACE0;
        send_job(40'h77_6655_4433, 16'd64, pl);
        wait_drain();
        repeat (4) tick();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
